floppy_sound_ctrl: RTL and testbench
====================================

FLOPPY_SOUND_CTRL -- requirements
Module: floppy_sound_ctrl

Interface
REQ-001 SHALL have parameter MOTOR_HOLD, default 1000, meaning motor run-on time in tick units after motor request drops.
REQ-002 SHALL have parameter STEP_GAP, default 3, meaning the minimum tick count between emitted step clicks.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, one-clk timebase strobe, nominally 1 kHz.
REQ-006 SHALL have port enable, input, 1, sound enable.
REQ-007 SHALL have port motor_req, input, 1, disk motor soft-switch level.
REQ-008 SHALL have port ph_in, input, 4, stepper phase magnet levels of the selected drive.
REQ-009 SHALL have port motor, output, 1, motor-noise enable to the sound mixer.
REQ-010 SHALL have port phs, output, 4, one-hot click pulses to the sound mixer.
REQ-011 SHALL have port pending, output, 3, step FIFO occupancy, 0..4.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when a step event is dropped.

Function
REQ-013 SHALL implement motor FSM states OFF, ON, HOLD; all transitions occur on the clk edge.
REQ-014 SHALL move OFF->ON when motor_req=1, and HOLD->ON when motor_req=1, clearing the hold counter.
REQ-015 SHALL move ON->HOLD when motor_req=0, loading the hold counter with MOTOR_HOLD.
REQ-016 SHALL, in HOLD, decrement the hold counter on each tick, and move HOLD->OFF on a tick that finds the counter at 1.
REQ-017 SHALL set internal motor_on=1 in states ON and HOLD, and drive motor = motor_on AND enable, registered.
REQ-018 SHALL register ph_in into prev_ph every cycle, and define rise = ph_in AND NOT prev_ph.
REQ-019 SHALL raise a step event when rise!=0 and motor_on=1; step events while OFF are ignored.
REQ-020 SHALL push into the FIFO only the lowest set bit index of rise (2 bits) when several phase bits rise in the same cycle.
REQ-021 SHALL use a 4-entry FIFO with a 2-bit index per entry, holding events in order.
REQ-022 SHALL, on a push while full without a same-cycle pop, drop the event and set overflow=1 until reset.
REQ-023 SHALL pop when pending>0, the gap counter is 0 and enable=1.
REQ-024 SHALL, on a pop, drive phs = one-hot of the head index for exactly one clk on the next cycle, and load the gap counter with STEP_GAP.
REQ-025 SHALL decrement the gap counter on tick, saturating at 0.
REQ-026 SHALL, on a same-cycle push and pop, perform both, leaving pending unchanged; a push to a full FIFO with a concurrent pop is accepted.
REQ-027 SHALL hold phs=0 at all other times, so no two consecutive cycles carry phs!=0.
REQ-028 SHALL, while enable=0, flush the FIFO, hold phs=0 and motor=0; the FSM and hold counter keep running.
REQ-029 SHALL clear the FIFO when the FSM enters OFF.
REQ-030 SHALL make pending equal to the registered FIFO count.

Reset
REQ-031 SHALL, with reset=1, set FSM=OFF, hold counter=0, gap counter=0, FIFO empty, pending=0, overflow=0, motor=0, phs=0.
REQ-032 SHALL, with reset=1, load prev_ph from ph_in, so phases already high at reset release cause no click.
REQ-033 SHALL give reset priority over all other inputs; a reset mid-HOLD or mid-gap aborts it immediately.

Verification
REQ-034 SHALL test motor run-on: enable=1, motor_req 1 then 0, MOTOR_HOLD=5 -> motor stays 1 through 4 ticks and drops after the 5th tick.
REQ-035 SHALL test re-request during HOLD: motor_req drops, then returns after 2 ticks -> motor stays 1 continuously and FSM=ON.
REQ-036 SHALL test click pacing: motor on, STEP_GAP=3, rising edges on ph_in bits 0,1,2 in three consecutive cycles -> phs=0001, 0010, 0100 as single-cycle pulses spaced by 3 ticks, with pending counting 3->0.
REQ-037 SHALL test overflow: with gap blocking pops, six rising events -> pending=4, overflow=1, and the first four indices are emitted in order.
REQ-038 SHALL test simultaneous rise and filtering: ph_in 0000->0110 -> one event with phs=0010; with the motor OFF the same stimulus gives no event and pending=0.
REQ-039 SHALL test reset and enable: ph_in=1111 held through reset -> no click after release; enable=0 with pending=2 -> pending=0, motor=0, phs=0.

Source files
------------

// File: rtl/floppy_sound_ctrl.sv
// Disk-drive sound effects controller: motor run-on FSM plus a paced
// click generator fed by a small FIFO of stepper phase rising edges.
module floppy_sound_ctrl #(
  parameter int MOTOR_HOLD = 1000,
  parameter int STEP_GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       motor_req,
  input  logic [3:0] ph_in,
  output logic       motor,
  output logic [3:0] phs,
  output logic [2:0] pending,
  output logic       overflow
);

  localparam int HOLD_W = (MOTOR_HOLD < 1) ? 1 : $clog2(MOTOR_HOLD + 1);
  localparam int GAP_W  = (STEP_GAP < 1) ? 1 : $clog2(STEP_GAP + 1);

  typedef enum logic [1:0] {S_OFF, S_ON, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [3:0]        prev_ph_q;
  logic [1:0]        mem_q [4];
  logic [1:0]        mem_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              motor_q, motor_d;
  logic [3:0]        phs_q, phs_d;

  logic       motor_on, enter_off, step, full, pop, push, drop, flush;
  logic [3:0] rise;
  logic [1:0] step_idx;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_OFF: if (motor_req) state_d = S_ON;
      S_ON: if (!motor_req) begin
        state_d = S_HOLD;
        hold_d  = HOLD_W'(MOTOR_HOLD);
      end
      S_HOLD: begin
        if (motor_req) begin
          state_d = S_ON;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            state_d = S_OFF;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  assign motor_on  = (state_q != S_OFF);
  assign enter_off = (state_d == S_OFF) && (state_q != S_OFF);
  assign rise      = ph_in & ~prev_ph_q;
  assign step      = motor_on && (rise != 4'd0);

  // Only the lowest rising phase is recorded when several rise together.
  always_comb begin
    step_idx = 2'd3;
    if (rise[0])      step_idx = 2'd0;
    else if (rise[1]) step_idx = 2'd1;
    else if (rise[2]) step_idx = 2'd2;
  end

  // The phs_q term keeps clicks apart even when STEP_GAP is zero.
  assign full  = (count_q == 3'd4);
  assign pop   = (count_q != 3'd0) && (gap_q == '0) && enable && (phs_q == 4'd0);
  assign push  = step && (!full || pop);
  assign drop  = step && full && !pop && enable;
  assign flush = !enable || enter_off;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    if (push) begin
      mem_d[wr_ptr_q] = step_idx;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (flush) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (pop)                         gap_d = GAP_W'(STEP_GAP);
    else if (tick && (gap_q != '0))  gap_d = gap_q - GAP_W'(1);
    phs_d      = pop ? (4'b0001 << mem_q[rd_ptr_q]) : 4'd0;
    overflow_d = overflow_q | drop;
    motor_d    = motor_on & enable;
  end

  always_ff @(posedge clk) begin
    prev_ph_q <= ph_in;
    mem_q     <= mem_d;
    if (reset) begin
      state_q    <= S_OFF;
      hold_q     <= '0;
      gap_q      <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      motor_q    <= 1'b0;
      phs_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      motor_q    <= motor_d;
      phs_q      <= phs_d;
    end
  end

  assign motor    = motor_q;
  assign phs      = phs_q;
  assign pending  = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_floppy_sound_ctrl.sv
// Bench for floppy_sound_ctrl: directed stimulus queues the expected clicks,
// a negedge monitor pops and compares each phs pulse as it appears.
module tb_floppy_sound_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, enable, motor_req;
  logic [3:0] ph_in;
  logic       motor;
  logic [3:0] phs;
  logic [2:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_phs = 4'd0;

  floppy_sound_ctrl #(.MOTOR_HOLD(5), .STEP_GAP(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .motor_req(motor_req), .ph_in(ph_in), .motor(motor), .phs(phs),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (actual running, required finished)");
    $fatal(1, "timeout");
  end

  // Monitor: every click must match the next queued expectation.
  always @(negedge clk) begin
    if (phs != 4'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL click_unexpected: actual phs=%b required none", phs);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (phs !== e) begin
          errors++;
          $display("FAIL click_value: actual phs=%b required %b", phs, e);
        end
      end
      checks++;
      if (prev_phs != 4'd0) begin
        errors++;
        $display("FAIL click_width: actual consecutive phs=%b,%b required single-cycle", prev_phs, phs);
      end
    end
    prev_phs = phs;
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b1; motor_req = 1'b0; ph_in = 4'd0;
    repeat (3) clk1();
    chk("rst_motor", motor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_phs", phs, 0);
    reset = 1'b0;
    clk1();

    // Motor run-on: 5 ticks of hold
    motor_req = 1'b1; clk1(); clk1();
    chk("runon_on", motor, 1);
    motor_req = 1'b0; clk1();
    repeat (4) do_tick();
    clk1();
    chk("runon_4ticks", motor, 1);
    do_tick(); clk1();
    chk("runon_off", motor, 0);

    // Re-request during hold
    motor_req = 1'b1; clk1(); clk1();
    chk("rereq_on", motor, 1);
    motor_req = 1'b0; clk1();
    do_tick(); chk("rereq_t1", motor, 1);
    do_tick(); chk("rereq_t2", motor, 1);
    motor_req = 1'b1; clk1();
    chk("rereq_back", motor, 1);
    repeat (6) do_tick();
    clk1();
    chk("rereq_still_on", motor, 1);

    // Click pacing: one priming click loads the gap, then three queued edges
    exp_q.push_back(4'b1000);
    ph_in = 4'b1000; clk1(); clk1(); clk1();
    chk("pace_prime_pending", pending, 0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    ph_in = 4'b1001; clk1();
    ph_in = 4'b1011; clk1();
    ph_in = 4'b1111; clk1();
    chk("pace_pending3", pending, 3);
    for (int k = 0; k < 3; k++) begin
      repeat (3) do_tick();
      chk("pace_hold", pending, 32'(3 - k));
      clk1();
      chk("pace_pop", pending, 32'(2 - k));
    end

    // Overflow: gap blocks pops while six edges arrive
    for (int i = 0; i < 6; i++) begin
      ph_in = 4'b0000; clk1();
      ph_in = 4'b0001 << (i % 4); clk1();
      if (i == 3) begin
        chk("ovf_full_pending", pending, 4);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_pending", pending, 4);
    chk("ovf_flag", overflow, 1);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    repeat (16) do_tick();
    clk1(); clk1();
    chk("ovf_drained", pending, 0);
    chk("ovf_sticky", overflow, 1);

    // Simultaneous rise picks lowest bit
    ph_in = 4'b0000; clk1();
    exp_q.push_back(4'b0010);
    ph_in = 4'b0110; clk1();
    chk("simul_pending", pending, 1);
    repeat (4) do_tick();
    clk1();
    chk("simul_drained", pending, 0);

    // Same stimulus with motor off is ignored
    motor_req = 1'b0; clk1();
    repeat (5) do_tick();
    clk1();
    chk("off_motor", motor, 0);
    ph_in = 4'b0000; clk1();
    ph_in = 4'b0110; clk1(); clk1();
    chk("off_pending", pending, 0);

    // Phases high through reset give no click
    ph_in = 4'b1111; motor_req = 1'b1; reset = 1'b1;
    clk1(); clk1();
    reset = 1'b0;
    repeat (4) clk1();
    chk("rel_pending", pending, 0);
    chk("rel_overflow", overflow, 0);
    chk("rel_motor", motor, 1);

    // Enable low flushes queued events
    ph_in = 4'b0000; clk1();
    exp_q.push_back(4'b0001);
    ph_in = 4'b0001; clk1(); clk1(); clk1();
    ph_in = 4'b0000; clk1();
    ph_in = 4'b0010; clk1();
    ph_in = 4'b0000; clk1();
    ph_in = 4'b0100; clk1();
    chk("en_pending2", pending, 2);
    enable = 1'b0; clk1(); clk1();
    chk("en_flush_pending", pending, 0);
    chk("en_flush_motor", motor, 0);
    chk("en_flush_phs", phs, 0);
    enable = 1'b1;
    repeat (4) do_tick();
    clk1();
    chk("en_back_pending", pending, 0);
    chk("en_back_motor", motor, 1);

    repeat (3) clk1();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
